// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM-subset control unit.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_STEP,
        S_HALT
    } state_t;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // ImmSrc encodings
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // Instruction classes in Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands in Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition codes in Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [31:0] HALT_INSTR = 32'hEF000000;

endpackage

// File: rtl/cpu_sequencer_cond_check.sv
// Evaluates an ARM condition field against registered NZCV flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Standard ARM condition table; 1111 behaves as AL
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Decode, NZCV ownership and run/step/halt sequencing for the single-cycle datapath.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        pc_en,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        PCSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  flags,
    output logic        halted
);

    state_t state, state_nxt;

    logic       is_halt, exec, cond_pass, commit, show;
    logic       alu_src_d, memtoreg_d, reg_w_d, mem_w_d, flag_w_d, branch_d;
    logic [1:0] reg_src_d, imm_src_d;
    logic [2:0] alu_ctl_d;

    cond_check u_cond (
        .cond  (Instr[31:28]),
        .flags (flags),
        .pass  (cond_pass)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Run/step/halt transitions; a halt instruction wins over run/step changes
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run) state_nxt = S_RUN;
                     else if (step) state_nxt = S_STEP;
            S_RUN:   if (is_halt) state_nxt = S_HALT;
                     else if (!run) state_nxt = S_PAUSE;
            S_PAUSE: if (run) state_nxt = S_RUN;
                     else if (step) state_nxt = S_STEP;
            S_STEP:  state_nxt = is_halt ? S_HALT : S_PAUSE;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Raw instruction decode, before any execution or condition gating
    always_comb begin
        alu_src_d  = 1'b0;
        imm_src_d  = IMM_DP;
        reg_src_d  = 2'b00;
        memtoreg_d = 1'b0;
        alu_ctl_d  = ALU_ADD;
        reg_w_d    = 1'b0;
        mem_w_d    = 1'b0;
        flag_w_d   = 1'b0;
        branch_d   = 1'b0;
        case (Instr[27:26])
            OP_DP: begin
                alu_src_d = Instr[25];
                case (Instr[24:21])
                    CMD_AND: begin alu_ctl_d = ALU_AND; reg_w_d = 1'b1; flag_w_d = Instr[20]; end
                    CMD_EOR: begin alu_ctl_d = ALU_EOR; reg_w_d = 1'b1; flag_w_d = Instr[20]; end
                    CMD_SUB: begin alu_ctl_d = ALU_SUB; reg_w_d = 1'b1; flag_w_d = Instr[20]; end
                    CMD_ADD: begin alu_ctl_d = ALU_ADD; reg_w_d = 1'b1; flag_w_d = Instr[20]; end
                    CMD_ORR: begin alu_ctl_d = ALU_ORR; reg_w_d = 1'b1; flag_w_d = Instr[20]; end
                    CMD_MOV: begin alu_ctl_d = ALU_MOV; reg_w_d = 1'b1; flag_w_d = Instr[20]; end
                    // Compare: subtract for flags only, no destination write
                    CMD_CMP: begin alu_ctl_d = ALU_SUB; flag_w_d = 1'b1; end
                    default: ;
                endcase
            end
            OP_MEM: begin
                alu_src_d = 1'b1;
                imm_src_d = IMM_MEM;
                if (Instr[20]) begin
                    reg_w_d    = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    mem_w_d   = 1'b1;
                    reg_src_d = 2'b10;
                end
            end
            OP_BR: begin
                reg_src_d = 2'b01;
                imm_src_d = IMM_BR;
                alu_src_d = 1'b1;
                branch_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // An instruction retires only in RUN/STEP, never for the halt word and never under reset
    assign is_halt = (Instr == HALT_INSTR);
    assign exec    = ((state == S_RUN) || (state == S_STEP)) && !is_halt && !rst;
    assign commit  = exec && cond_pass;
    assign show    = (state != S_IDLE);

    assign pc_en      = exec;
    assign RegWrite   = commit && reg_w_d;
    assign MemWrite   = commit && mem_w_d;
    assign PCSrc      = commit && (branch_d || (reg_w_d && (Instr[15:12] == 4'hF)));
    assign ALUSrc     = show && alu_src_d;
    assign MemtoReg   = show && memtoreg_d;
    assign RegSrc     = show ? reg_src_d : 2'b00;
    assign ImmSrc     = show ? imm_src_d : IMM_DP;
    assign ALUControl = show ? alu_ctl_d : ALU_ADD;
    assign halted     = (state == S_HALT);

    // NZCV register, loaded at the end of a retiring flag-setting instruction
    always_ff @(posedge clk) begin
        if (rst)                        flags <= 4'b0000;
        else if (commit && flag_w_d)    flags <= ALUFlags;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed and randomized checks of cpu_sequencer against a behavioural model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        pc_en, RegWrite, MemWrite, MemtoReg, ALUSrc, PCSrc, halted;
    logic [1:0]  RegSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  flags;

    cpu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .pc_en      (pc_en),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .PCSrc      (PCSrc),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .flags      (flags),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3, M_HALT = 4;
    localparam logic [31:0] HALT_WORD = 32'hEF000000;

    typedef struct packed {
        logic       pc_en, rw, mw, m2r, asrc, pcs, fw;
        logic [1:0] rsrc, isrc;
        logic [2:0] alu;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_mode;
    logic [3:0] m_flags;
    exp_t last_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            0: return z;              1: return !z;
            2: return cy;             3: return !cy;
            4: return n;              5: return !n;
            6: return v;              7: return !v;
            8: return cy && !z;       9: return !cy || z;
            10: return n == v;        11: return n != v;
            12: return !z && n == v;  13: return z || n != v;
            default: return 1'b1;
        endcase
    endfunction

    // What the control outputs must be for this instruction in this mode
    function automatic exp_t model(input logic [31:0] ins, input int mode,
                                   input logic [3:0] fl, input logic r);
        exp_t e;
        bit wr_reg, wr_mem, setf, br, live, go;
        e = '0; wr_reg = 0; wr_mem = 0; setf = 0; br = 0;
        case (ins[27:26])
            2'd0: begin
                e.asrc = ins[25];
                case (ins[24:21])
                    4'h0: begin e.alu = 3'd2; wr_reg = 1; setf = ins[20]; end
                    4'h1: begin e.alu = 3'd4; wr_reg = 1; setf = ins[20]; end
                    4'h2: begin e.alu = 3'd1; wr_reg = 1; setf = ins[20]; end
                    4'h4: begin e.alu = 3'd0; wr_reg = 1; setf = ins[20]; end
                    4'hC: begin e.alu = 3'd3; wr_reg = 1; setf = ins[20]; end
                    4'hD: begin e.alu = 3'd5; wr_reg = 1; setf = ins[20]; end
                    4'hA: begin e.alu = 3'd1; setf = 1; end
                    default: e.alu = 3'd0;
                endcase
            end
            2'd1: begin
                e.asrc = 1; e.isrc = 2'b01;
                if (ins[20]) begin wr_reg = 1; e.m2r = 1; end
                else begin wr_mem = 1; e.rsrc = 2'b10; end
            end
            2'd2: begin
                e.rsrc = 2'b01; e.isrc = 2'b10; e.asrc = 1; br = 1;
            end
            default: ;
        endcase
        live = (mode == M_RUN || mode == M_STEP) && ins != HALT_WORD && !r;
        go   = live && cond_ok(ins[31:28], fl);
        e.pc_en = live;
        e.rw    = go && wr_reg;
        e.mw    = go && wr_mem;
        e.pcs   = go && (br || (wr_reg && ins[15:12] == 4'hF));
        e.fw    = go && setf;
        if (mode == M_IDLE) begin
            e.asrc = 0; e.m2r = 0; e.rsrc = 0; e.isrc = 0; e.alu = 0;
        end
        return e;
    endfunction

    // Compare all outputs against the model mid-cycle
    task automatic sample(input string tag);
        exp_t e;
        @(negedge clk);
        e = model(Instr, m_mode, m_flags, rst);
        last_e = e;
        chk({tag, ".pc_en"},    pc_en,    e.pc_en);
        chk({tag, ".RegWrite"}, RegWrite, e.rw);
        chk({tag, ".MemWrite"}, MemWrite, e.mw);
        chk({tag, ".PCSrc"},    PCSrc,    e.pcs);
        chk({tag, ".flags"},    flags,    m_flags);
        chk({tag, ".halted"},   halted,   m_mode == M_HALT);
        if (!rst) begin
            chk({tag, ".ALUControl"}, ALUControl, e.alu);
            chk({tag, ".ALUSrc"},     ALUSrc,     e.asrc);
            chk({tag, ".ImmSrc"},     ImmSrc,     e.isrc);
            chk({tag, ".RegSrc"},     RegSrc,     e.rsrc);
            chk({tag, ".MemtoReg"},   MemtoReg,   e.m2r);
        end
    endtask

    // Move the model across the next rising edge along with the DUT
    task automatic advance();
        int nm;
        logic [3:0] nf;
        bit hi;
        hi = (Instr == HALT_WORD);
        nm = m_mode; nf = m_flags;
        if (rst) begin
            nm = M_IDLE; nf = 4'b0000;
        end else begin
            if (last_e.fw) nf = ALUFlags;
            case (m_mode)
                M_IDLE:  nm = run ? M_RUN : (step ? M_STEP : M_IDLE);
                M_RUN:   nm = hi ? M_HALT : (!run ? M_PAUSE : M_RUN);
                M_PAUSE: nm = run ? M_RUN : (step ? M_STEP : M_PAUSE);
                M_STEP:  nm = hi ? M_HALT : M_PAUSE;
                default: nm = M_HALT;
            endcase
        end
        @(posedge clk);
        #1;
        m_mode = nm; m_flags = nf;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        if ($urandom_range(0, 39) == 0) return HALT_WORD;
        ins = $urandom;
        if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
        if (ins[27:26] == 2'b00 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 6))
                0: ins[24:21] = 4'h0;  1: ins[24:21] = 4'h1;
                2: ins[24:21] = 4'h2;  3: ins[24:21] = 4'h4;
                4: ins[24:21] = 4'hC;  5: ins[24:21] = 4'hD;
                default: ins[24:21] = 4'hA;
            endcase
        end
        if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
        return ins;
    endfunction

    initial begin
        last_e = '0;
        m_mode = M_IDLE; m_flags = 4'b0000;
        rst = 1; run = 0; step = 0; Instr = 32'h0; ALUFlags = 4'h0;
        #1;
        advance();
        advance();

        // Reset release with run low
        rst = 0;
        sample("reset");
        chk("reset.pc_en_const", pc_en, 1'b0);
        chk("reset.flags_const", flags, 4'b0000);
        advance();

        // ADDS R0,R1,#1 while running
        run = 1; Instr = 32'hE2910001; ALUFlags = 4'b0100;
        sample("adds_idle");
        advance();
        sample("adds");
        chk("adds.RegWrite_const", RegWrite, 1'b1);
        chk("adds.ALUSrc_const", ALUSrc, 1'b1);
        chk("adds.ALUControl_const", ALUControl, 3'b000);
        chk("adds.pc_en_const", pc_en, 1'b1);
        advance();
        chk("adds.flags_next", flags, 4'b0100);

        // BEQ taken with Z set
        Instr = 32'h0A000002;
        sample("beq_taken");
        chk("beq.PCSrc_taken", PCSrc, 1'b1);
        chk("beq.RegSrc_const", RegSrc, 2'b01);
        chk("beq.ImmSrc_const", ImmSrc, 2'b10);
        advance();
        // clear flags, then BEQ not taken
        Instr = 32'hE2910001; ALUFlags = 4'b0000;
        sample("adds_clear");
        advance();
        Instr = 32'h0A000002;
        sample("beq_nt");
        chk("beq.PCSrc_not_taken", PCSrc, 1'b0);
        chk("beq.pc_en_not_taken", pc_en, 1'b1);
        advance();

        // STR R2,[R1,#4]
        Instr = 32'hE5812004;
        sample("str");
        chk("str.MemWrite_const", MemWrite, 1'b1);
        chk("str.RegSrc_const", RegSrc, 2'b10);
        chk("str.ImmSrc_const", ImmSrc, 2'b01);
        chk("str.RegWrite_const", RegWrite, 1'b0);
        advance();

        // Drop to PAUSE, then a single step pulse
        run = 0; Instr = 32'hE2811001;
        sample("to_pause");
        advance();
        step = 1;
        sample("step_req");
        chk("step.pc_en_pause", pc_en, 1'b0);
        advance();
        step = 0;
        sample("step_exec");
        chk("step.pc_en_once", pc_en, 1'b1);
        advance();
        sample("step_after");
        chk("step.pc_en_back", pc_en, 1'b0);
        advance();
        sample("step_idle");
        advance();

        // Halt from RUN, then run toggling has no effect
        run = 1;
        sample("halt_pre");
        advance();
        Instr = HALT_WORD;
        sample("halt_instr");
        chk("halt.pc_en_halt_instr", pc_en, 1'b0);
        advance();
        Instr = 32'hE2810001;
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            sample("halt_hold");
            chk("halt.halted", halted, 1'b1);
            chk("halt.pc_en", pc_en, 1'b0);
            advance();
        end

        // Reset during RUN with a flag-setting instruction present
        rst = 1;
        advance();
        rst = 0; run = 1; ALUFlags = 4'b1111;
        advance();
        rst = 1; Instr = 32'hE2910001;
        sample("rst_mid_run");
        chk("rst_mid.RegWrite", RegWrite, 1'b0);
        advance();
        rst = 0; run = 0;
        sample("rst_after");
        chk("rst_after.flags", flags, 4'b0000);
        advance();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) run = ~run;
            step     = ($urandom_range(0, 3) == 0);
            Instr    = rand_instr();
            ALUFlags = 4'($urandom_range(0, 15));
            sample("rand");
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
